// File: rtl/pixel_stream_fifo_if.sv
// Pixel stream handshake bundle: upstream beat side and downstream sink side of the FIFO.
// master = environment (source and sink), slave = the FIFO itself.
interface pixel_stream_fifo_if;
  logic [63:0] pixel_stream_in;
  logic        valid_in;
  logic        ready_out;
  logic        start_of_frame_in;
  logic        end_of_line_in;
  logic [63:0] pixel_stream_out;
  logic        valid_out;
  logic        ready_in;
  logic        start_of_frame_out;
  logic        end_of_line_out;

  modport master (
    output pixel_stream_in, valid_in, start_of_frame_in, end_of_line_in, ready_in,
    input  ready_out, pixel_stream_out, valid_out, start_of_frame_out, end_of_line_out
  );

  modport slave (
    input  pixel_stream_in, valid_in, start_of_frame_in, end_of_line_in, ready_in,
    output ready_out, pixel_stream_out, valid_out, start_of_frame_out, end_of_line_out
  );
endinterface

// File: rtl/pixel_stream_fifo.sv
// Registered pixel-beat FIFO (no fall-through) carrying SOF/EOL markers with each beat,
// plus input-side line/column tracking that flags malformed frames with sticky errors.
module pixel_stream_fifo #(
  parameter int DEPTH           = 16,
  parameter int BEATS_PER_LINE  = 960,
  parameter int LINES_PER_FRAME = 1080
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clock_en,
  pixel_stream_fifo_if.slave       bus,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [15:0]              frame_count,
  input  logic                     clear_errors,
  output logic                     err_early_eol,
  output logic                     err_missing_eol,
  output logic                     err_bad_sof
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int OCC_W  = PTR_W + 1;
  localparam int COL_W  = (BEATS_PER_LINE > 1) ? $clog2(BEATS_PER_LINE) : 1;
  localparam int LINE_W = (LINES_PER_FRAME > 1) ? $clog2(LINES_PER_FRAME) : 1;
  localparam logic [OCC_W-1:0]  OCC_FULL  = OCC_W'(DEPTH);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(BEATS_PER_LINE - 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(LINES_PER_FRAME - 1);

  logic [65:0]       mem_q [DEPTH];
  logic [65:0]       mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [COL_W-1:0]  col_q, col_d, col_eff_s;
  logic [LINE_W-1:0] line_q, line_d, line_eff_s;
  logic [15:0]       frame_count_q, frame_count_d;
  logic              err_early_q, err_early_d, err_missing_q, err_missing_d, err_bad_q, err_bad_d;
  logic              ready_s, valid_s, wr_en_s, rd_en_s, line_end_s;
  logic              set_early_s, set_missing_s, set_bad_s;

  // Handshake qualification; ready drops combinationally while reset is asserted.
  always_comb begin
    ready_s = (occ_q != OCC_FULL) && !reset;
    valid_s = (occ_q != {OCC_W{1'b0}});
    wr_en_s = bus.valid_in & ready_s & clock_en;
    rd_en_s = valid_s & bus.ready_in & clock_en;
  end

  // Storage, pointers and occupancy next-state.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (wr_en_s) begin
      mem_d[wr_ptr_q] = {bus.pixel_stream_in, bus.start_of_frame_in, bus.end_of_line_in};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_en_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_en_s, rd_en_s})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Frame position tracking; an SOF beat is always treated as column 0 of line 0.
  always_comb begin
    col_eff_s     = bus.start_of_frame_in ? {COL_W{1'b0}} : col_q;
    line_eff_s    = bus.start_of_frame_in ? {LINE_W{1'b0}} : line_q;
    line_end_s    = bus.end_of_line_in || (col_eff_s == COL_LAST);
    col_d         = col_q;
    line_d        = line_q;
    frame_count_d = frame_count_q;
    set_early_s   = 1'b0;
    set_missing_s = 1'b0;
    set_bad_s     = 1'b0;
    if (wr_en_s) begin
      if (line_end_s) begin
        col_d  = {COL_W{1'b0}};
        line_d = (line_eff_s == LINE_LAST) ? {LINE_W{1'b0}} : line_eff_s + LINE_W'(1);
      end else begin
        col_d  = col_eff_s + COL_W'(1);
        line_d = line_eff_s;
      end
      if (bus.start_of_frame_in) begin
        frame_count_d = frame_count_q + 16'd1;
        set_bad_s     = (col_q != {COL_W{1'b0}}) || (line_q != {LINE_W{1'b0}});
      end else begin
        frame_count_d = frame_count_q;
      end
      set_early_s   = bus.end_of_line_in && (col_eff_s != COL_LAST);
      set_missing_s = !bus.end_of_line_in && (col_eff_s == COL_LAST);
    end else begin
      col_d = col_q;
    end
  end

  // Sticky error flags: a same-cycle set beats clear, and a stall ignores both.
  always_comb begin
    if (clock_en) begin
      err_early_d   = (err_early_q   & ~clear_errors) | set_early_s;
      err_missing_d = (err_missing_q & ~clear_errors) | set_missing_s;
      err_bad_d     = (err_bad_q     & ~clear_errors) | set_bad_s;
    end else begin
      err_early_d   = err_early_q;
      err_missing_d = err_missing_q;
      err_bad_d     = err_bad_q;
    end
  end

  // Control and status state with synchronous reset (independent of clock_en).
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q      <= {PTR_W{1'b0}};
      rd_ptr_q      <= {PTR_W{1'b0}};
      occ_q         <= {OCC_W{1'b0}};
      col_q         <= {COL_W{1'b0}};
      line_q        <= {LINE_W{1'b0}};
      frame_count_q <= 16'd0;
      err_early_q   <= 1'b0;
      err_missing_q <= 1'b0;
      err_bad_q     <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      occ_q         <= occ_d;
      col_q         <= col_d;
      line_q        <= line_d;
      frame_count_q <= frame_count_d;
      err_early_q   <= err_early_d;
      err_missing_q <= err_missing_d;
      err_bad_q     <= err_bad_d;
    end
  end

  // Payload storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  assign bus.ready_out          = ready_s;
  assign bus.valid_out          = valid_s;
  assign bus.pixel_stream_out   = mem_q[rd_ptr_q][65:2];
  assign bus.start_of_frame_out = mem_q[rd_ptr_q][1];
  assign bus.end_of_line_out    = mem_q[rd_ptr_q][0];
  assign occupancy              = occ_q;
  assign frame_count            = frame_count_q;
  assign err_early_eol          = err_early_q;
  assign err_missing_eol        = err_missing_q;
  assign err_bad_sof            = err_bad_q;
endmodule

// File: tb/tb_pixel_stream_fifo.sv
// Directed table-driven bench for pixel_stream_fifo (DEPTH=4, 4 beats/line, 2 lines/frame).
module tb_pixel_stream_fifo;
  logic        clock = 1'b0;
  logic        reset;
  logic        clock_en;
  logic        clear_errors;
  logic [2:0]  occupancy;
  logic [15:0] frame_count;
  logic        err_early_eol, err_missing_eol, err_bad_sof;
  int          n_pass  = 0;
  int          n_total = 0;

  pixel_stream_fifo_if bus ();

  pixel_stream_fifo #(.DEPTH(4), .BEATS_PER_LINE(4), .LINES_PER_FRAME(2)) dut (
    .clock(clock), .reset(reset), .clock_en(clock_en), .bus(bus),
    .occupancy(occupancy), .frame_count(frame_count), .clear_errors(clear_errors),
    .err_early_eol(err_early_eol), .err_missing_eol(err_missing_eol), .err_bad_sof(err_bad_sof)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        ce, vi, sof, eol, ri, clr;
    logic [63:0] din;
    logic        e_rdy, e_vo;
    logic [63:0] e_dout;
    logic [1:0]  e_mk;
    logic [2:0]  e_occ;
    logic [15:0] e_fc;
    logic [2:0]  e_err;
  } vec_t;

  function automatic vec_t mk(input logic ce, vi, sof, eol, ri, clr, input logic [63:0] din,
                              input logic rdy, vo, input logic [63:0] dout, input logic [1:0] mkr,
                              input logic [2:0] occ, input logic [15:0] fc, input logic [2:0] err);
    vec_t v;
    v.ce = ce; v.vi = vi; v.sof = sof; v.eol = eol; v.ri = ri; v.clr = clr; v.din = din;
    v.e_rdy = rdy; v.e_vo = vo; v.e_dout = dout; v.e_mk = mkr; v.e_occ = occ; v.e_fc = fc; v.e_err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic ce, vi, sof, eol, ri, clr, input logic [63:0] din);
    clock_en = ce; bus.valid_in = vi; bus.start_of_frame_in = sof; bus.end_of_line_in = eol;
    bus.ready_in = ri; clear_errors = clr; bus.pixel_stream_in = din;
  endtask

  task automatic check_state(input string tag, input logic rdy, vo, input logic [63:0] dout,
                             input logic [1:0] mkr, input logic [2:0] occ, input logic [15:0] fc,
                             input logic [2:0] err);
    chk({tag, "_ready_out"}, {63'd0, bus.ready_out}, {63'd0, rdy});
    chk({tag, "_valid_out"}, {63'd0, bus.valid_out}, {63'd0, vo});
    chk({tag, "_occupancy"}, {61'd0, occupancy}, {61'd0, occ});
    chk({tag, "_frame_count"}, {48'd0, frame_count}, {48'd0, fc});
    chk({tag, "_errors"}, {61'd0, err_early_eol, err_missing_eol, err_bad_sof}, {61'd0, err});
    if (vo) begin
      chk({tag, "_data"}, bus.pixel_stream_out, dout);
      chk({tag, "_markers"}, {62'd0, bus.start_of_frame_out, bus.end_of_line_out}, {62'd0, mkr});
    end
  endtask

  vec_t tbl[34];

  initial begin
    // ce vi sof eol ri clr din | rdy vo dout mk occ fc err{early,missing,bad}
    tbl[0]  = mk(1,1,1,0,0,0,64'h1,  1,1,64'h1, 2'b10,3'd1,16'd1,3'b000);
    tbl[1]  = mk(1,1,0,0,0,0,64'h2,  1,1,64'h1, 2'b10,3'd2,16'd1,3'b000);
    tbl[2]  = mk(1,1,0,0,0,0,64'h3,  1,1,64'h1, 2'b10,3'd3,16'd1,3'b000);
    tbl[3]  = mk(1,1,0,1,0,0,64'h4,  0,1,64'h1, 2'b10,3'd4,16'd1,3'b000);
    tbl[4]  = mk(1,1,0,0,0,0,64'h5,  0,1,64'h1, 2'b10,3'd4,16'd1,3'b000);
    tbl[5]  = mk(1,1,0,0,1,0,64'h5,  1,1,64'h2, 2'b00,3'd3,16'd1,3'b000);
    tbl[6]  = mk(1,1,0,0,1,0,64'h5,  1,1,64'h3, 2'b00,3'd3,16'd1,3'b000);
    tbl[7]  = mk(1,0,0,0,1,0,64'h0,  1,1,64'h4, 2'b01,3'd2,16'd1,3'b000);
    tbl[8]  = mk(1,0,0,0,1,0,64'h0,  1,1,64'h5, 2'b00,3'd1,16'd1,3'b000);
    tbl[9]  = mk(1,0,0,0,1,0,64'h0,  1,0,64'h0, 2'b00,3'd0,16'd1,3'b000);
    tbl[10] = mk(1,1,0,0,1,0,64'h10, 1,1,64'h10,2'b00,3'd1,16'd1,3'b000);
    tbl[11] = mk(1,1,0,0,1,0,64'h11, 1,1,64'h11,2'b00,3'd1,16'd1,3'b000);
    tbl[12] = mk(1,1,0,1,1,0,64'h12, 1,1,64'h12,2'b01,3'd1,16'd1,3'b000);
    tbl[13] = mk(1,1,1,0,1,0,64'h13, 1,1,64'h13,2'b10,3'd1,16'd2,3'b000);
    tbl[14] = mk(1,0,0,0,1,0,64'h0,  1,0,64'h0, 2'b00,3'd0,16'd2,3'b000);
    tbl[15] = mk(1,1,0,1,1,0,64'h20, 1,1,64'h20,2'b01,3'd1,16'd2,3'b100);
    tbl[16] = mk(1,1,0,0,1,0,64'h21, 1,1,64'h21,2'b00,3'd1,16'd2,3'b100);
    tbl[17] = mk(1,1,0,0,1,0,64'h22, 1,1,64'h22,2'b00,3'd1,16'd2,3'b100);
    tbl[18] = mk(1,1,0,0,1,0,64'h23, 1,1,64'h23,2'b00,3'd1,16'd2,3'b100);
    tbl[19] = mk(1,1,0,0,1,0,64'h24, 1,1,64'h24,2'b00,3'd1,16'd2,3'b110);
    tbl[20] = mk(1,1,0,0,1,0,64'h25, 1,1,64'h25,2'b00,3'd1,16'd2,3'b110);
    tbl[21] = mk(1,1,0,0,1,0,64'h26, 1,1,64'h26,2'b00,3'd1,16'd2,3'b110);
    tbl[22] = mk(1,1,1,0,1,0,64'h27, 1,1,64'h27,2'b10,3'd1,16'd3,3'b111);
    tbl[23] = mk(1,0,0,0,1,1,64'h0,  1,0,64'h0, 2'b00,3'd0,16'd3,3'b000);
    tbl[24] = mk(1,1,0,1,1,1,64'h28, 1,1,64'h28,2'b01,3'd1,16'd3,3'b100);
    tbl[25] = mk(1,0,0,0,1,1,64'h0,  1,0,64'h0, 2'b00,3'd0,16'd3,3'b000);
    tbl[26] = mk(1,1,0,0,1,0,64'h30, 1,1,64'h30,2'b00,3'd1,16'd3,3'b000);
    tbl[27] = mk(0,1,0,1,1,1,64'h31, 1,1,64'h30,2'b00,3'd1,16'd3,3'b000);
    tbl[28] = mk(0,1,0,1,1,1,64'h31, 1,1,64'h30,2'b00,3'd1,16'd3,3'b000);
    tbl[29] = mk(0,1,0,1,1,1,64'h31, 1,1,64'h30,2'b00,3'd1,16'd3,3'b000);
    tbl[30] = mk(1,1,0,0,1,0,64'h31, 1,1,64'h31,2'b00,3'd1,16'd3,3'b000);
    tbl[31] = mk(1,1,0,0,1,0,64'h32, 1,1,64'h32,2'b00,3'd1,16'd3,3'b000);
    tbl[32] = mk(1,1,0,1,1,0,64'h33, 1,1,64'h33,2'b01,3'd1,16'd3,3'b000);
    tbl[33] = mk(1,0,0,0,1,0,64'h0,  1,0,64'h0, 2'b00,3'd0,16'd3,3'b000);

    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    repeat (2) @(posedge clock);
    #1 check_state("reset", 1'b0, 1'b0, 64'h0, 2'b00, 3'd0, 16'd0, 3'b000);
    @(negedge clock);
    reset = 1'b0;
    #1 chk("ready_after_reset", {63'd0, bus.ready_out}, 64'd1);

    for (int i = 0; i < 34; i++) begin
      @(negedge clock);
      drive(tbl[i].ce, tbl[i].vi, tbl[i].sof, tbl[i].eol, tbl[i].ri, tbl[i].clr, tbl[i].din);
      @(posedge clock);
      #1 check_state($sformatf("v%0d", i), tbl[i].e_rdy, tbl[i].e_vo, tbl[i].e_dout, tbl[i].e_mk,
                     tbl[i].e_occ, tbl[i].e_fc, tbl[i].e_err);
    end

    // Reset with three beats stored, clock_en low: entries must be discarded.
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      drive(1'b1, 1'b1, (i == 0), 1'b0, 1'b0, 1'b0, 64'h40 + 64'(i));
    end
    @(posedge clock);
    #1 check_state("pre_reset", 1'b1, 1'b1, 64'h40, 2'b10, 3'd3, 16'd4, 3'b000);
    @(negedge clock);
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0);
    @(posedge clock);
    #1 check_state("mid_reset", 1'b0, 1'b0, 64'h0, 2'b00, 3'd0, 16'd0, 3'b000);
    @(negedge clock);
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0);
    #1 chk("ready_after_mid_reset", {63'd0, bus.ready_out}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1 chk($sformatf("no_stale_beat%0d", i), {63'd0, bus.valid_out}, 64'd0);
    end
    @(negedge clock);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h50);
    @(posedge clock);
    #1 check_state("post_reset_write", 1'b1, 1'b1, 64'h50, 2'b10, 3'd1, 16'd1, 3'b000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
